// File: rtl/store_unit_pkg.sv
// Shared constants for the store unit: store opcodes and access-size encodings.
package store_unit_pkg;

    // Store opcodes, taken from instr[31:26]
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    // Access-size encodings presented on data_size
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // True for the three opcodes this unit handles
    function automatic logic is_store_op(input logic [5:0] op);
        logic result;
        case (op)
            OP_SB:   result = 1'b1;
            OP_SH:   result = 1'b1;
            OP_SW:   result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Memory-side request/response bus between the store unit and the data interface.
interface store_unit_if #(
    parameter int ADDR_W = 32
) ();

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic [3:0]        data_wstrb;
    logic              data_addr_ok;
    logic              data_data_ok;

    // The store unit issues requests
    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wdata,
        output data_wstrb,
        input  data_addr_ok,
        input  data_data_ok
    );

    // The memory side accepts requests and reports completion
    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wdata,
        input  data_wstrb,
        output data_addr_ok,
        output data_data_ok
    );

endinterface

// File: rtl/store_unit_align.sv
// Combinational store alignment: byte strobes, lane-replicated data, size and
// misalignment detection from the opcode and the low address bits.
module store_align
    import store_unit_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rt_data,
    output logic        is_store,
    output logic [1:0]  size,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        misalign
);

    // Decode the store type and derive strobes, data lanes and alignment fault
    always_comb begin
        is_store = 1'b0;
        size     = SIZE_BYTE;
        wdata    = 32'h0000_0000;
        wstrb    = 4'b0000;
        misalign = 1'b0;
        case (opcode)
            OP_SB: begin
                is_store = 1'b1;
                size     = SIZE_BYTE;
                wdata    = {4{rt_data[7:0]}};
                wstrb    = 4'b0001 << addr_lo;
            end
            OP_SH: begin
                is_store = 1'b1;
                size     = SIZE_HALF;
                wdata    = {2{rt_data[15:0]}};
                case (addr_lo)
                    2'b00:   wstrb = 4'b0011;
                    2'b10:   wstrb = 4'b1100;
                    default: begin
                        wstrb    = 4'b0000;
                        misalign = 1'b1;
                    end
                endcase
            end
            OP_SW: begin
                is_store = 1'b1;
                size     = SIZE_WORD;
                wdata    = rt_data;
                if (addr_lo == 2'b00) begin
                    wstrb = 4'b1111;
                end else begin
                    wstrb    = 4'b0000;
                    misalign = 1'b1;
                end
            end
            default: begin
                is_store = 1'b0;
                size     = SIZE_BYTE;
                wdata    = 32'h0000_0000;
                wstrb    = 4'b0000;
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store unit: accepts aligned stores, issues one write request on the
// memory bus, stalls the pipeline until the write completes, and flags
// misaligned stores as address errors without touching memory.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    input  logic [31:0]       instr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       rt_data,
    input  logic              flush,
    store_unit_if.master      mem,
    output logic              ades,
    output logic [ADDR_W-1:0] badvaddr,
    output logic              stall,
    output logic              st_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_next;

    logic              al_is_store;
    logic [1:0]        al_size;
    logic [31:0]       al_wdata;
    logic [3:0]        al_wstrb;
    logic              al_misalign;

    logic              accept;

    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;

    // Only the opcode field of the instruction matters to this unit
    logic              instr_unused;
    assign instr_unused = ^instr[25:0];

    store_align u_align (
        .opcode   (instr[31:26]),
        .addr_lo  (addr[1:0]),
        .rt_data  (rt_data),
        .is_store (al_is_store),
        .size     (al_size),
        .wdata    (al_wdata),
        .wstrb    (al_wstrb),
        .misalign (al_misalign)
    );

    // A misaligned store raises the address error and is never accepted
    assign ades     = st_valid && al_misalign;
    assign badvaddr = addr;
    assign accept   = (state == S_IDLE) && st_valid && al_is_store
                      && !al_misalign && !flush && is_store_op(instr[31:26]);

    // Next-state logic; once data_addr_ok is seen the write is committed and flush no longer applies
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_REQ;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem.data_addr_ok) begin
                    if (mem.data_data_ok) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_WAIT;
                    end
                end else if (flush) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem.data_data_ok) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_WAIT;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the request fields on accept so they stay stable while the request is pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_size  <= 2'd0;
            req_addr  <= '0;
            req_wdata <= 32'h0000_0000;
            req_wstrb <= 4'b0000;
        end else if (accept) begin
            req_size  <= al_size;
            req_addr  <= addr;
            req_wdata <= al_wdata;
            req_wstrb <= al_wstrb;
        end else begin
            req_size  <= req_size;
            req_addr  <= req_addr;
            req_wdata <= req_wdata;
            req_wstrb <= req_wstrb;
        end
    end

    assign mem.data_req   = (state == S_REQ);
    assign mem.data_wr    = (state == S_REQ);
    assign mem.data_size  = req_size;
    assign mem.data_addr  = req_addr;
    assign mem.data_wdata = req_wdata;
    assign mem.data_wstrb = req_wstrb;

    // Stall covers the accept cycle, the whole request phase and the wait until completion;
    // rst forces it low immediately even if a store is presented during reset
    assign stall = !rst && (accept
                            || (state == S_REQ)
                            || ((state == S_WAIT) && !mem.data_data_ok));

    // Completion pulse: data_data_ok only counts while a write is outstanding
    assign st_done = ((state == S_WAIT) && mem.data_data_ok)
                     || ((state == S_REQ) && mem.data_addr_ok && mem.data_data_ok);

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: directed stores push expected requests into a
// queue; a negedge monitor pops and compares each new request on the memory bus.
module tb_store_unit;
    import store_unit_pkg::*;

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  sz;
        logic [31:0] wd;
        logic [3:0]  ws;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] rt_data;
    logic        flush;
    logic        ades;
    logic [31:0] badvaddr;
    logic        stall;
    logic        st_done;

    store_unit_if #(.ADDR_W(32)) mem ();

    store_unit #(.ADDR_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .st_valid (st_valid),
        .instr    (instr),
        .addr     (addr),
        .rt_data  (rt_data),
        .flush    (flush),
        .mem      (mem),
        .ades     (ades),
        .badvaddr (badvaddr),
        .stall    (stall),
        .st_done  (st_done)
    );

    always #5 clk = ~clk;

    req_t exp_q[$];
    req_t cur_r, exp_r, held_r;
    bit   in_req = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   exp_done = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each new request against the scoreboard, then check it holds stable
    always @(negedge clk) begin
        if (rst) begin
            in_req = 1'b0;
        end else begin
            if (st_done) done_cnt++;
            if (mem.data_req) begin
                check("req_wr", mem.data_wr, 1);
                cur_r = {mem.data_addr, mem.data_size, mem.data_wdata, mem.data_wstrb};
                if (!in_req) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_req", 1, 0);
                    end else begin
                        exp_r = exp_q.pop_front();
                        check("req_addr", cur_r.a, exp_r.a);
                        check("req_size", cur_r.sz, exp_r.sz);
                        check("req_wdata", cur_r.wd, exp_r.wd);
                        check("req_wstrb", cur_r.ws, exp_r.ws);
                    end
                    held_r = cur_r;
                    in_req = 1'b1;
                end else begin
                    check("req_stable", cur_r, held_r);
                end
            end else begin
                in_req = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        st_valid = 1'b0;
        instr = 32'h0;
        addr = 32'h0;
        rt_data = 32'h0;
        flush = 1'b0;
        mem.data_addr_ok = 1'b0;
        mem.data_data_ok = 1'b0;
    endtask

    task automatic present(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        instr = {op, 26'h0};
        addr = a;
        rt_data = d;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd, input logic [3:0] ws);
        req_t t;
        t.a = a; t.sz = sz; t.wd = wd; t.ws = ws;
        exp_q.push_back(t);
    endtask

    // Full store with the memory answering both handshakes in the first REQ cycle
    task automatic quick_store(input string name, input logic [5:0] op, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] sz, input logic [31:0] wd,
                               input logic [3:0] ws);
        push_exp(a, sz, wd, ws);
        present(op, a, d);
        #1;
        check({name, "_accept_stall"}, stall, 1);
        check({name, "_ades"}, ades, 0);
        tick();
        st_valid = 1'b0;
        mem.data_addr_ok = 1'b1;
        mem.data_data_ok = 1'b1;
        exp_done++;
        #1;
        check({name, "_done"}, st_done, 1);
        tick();
        mem.data_addr_ok = 1'b0;
        mem.data_data_ok = 1'b0;
        #1;
        check({name, "_idle_req"}, mem.data_req, 0);
        check({name, "_idle_stall"}, stall, 0);
    endtask

    initial begin
        int sc, rc, dc;
        rst = 1'b1;
        idle_inputs();
        #2;
        check("rst_req", mem.data_req, 0);
        check("rst_wr", mem.data_wr, 0);
        check("rst_size", mem.data_size, 0);
        check("rst_addr", mem.data_addr, 0);
        check("rst_wdata", mem.data_wdata, 0);
        check("rst_wstrb", mem.data_wstrb, 0);
        check("rst_stall", stall, 0);
        check("rst_done", st_done, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // SB at 0x1003: top byte lane, data replicated
        quick_store("sb_1003", OP_SB, 32'h0000_1003, 32'h0000_00A5, 2'd0, 32'hA5A5_A5A5, 4'b1000);

        // Misaligned SH: address error, no request, no stall
        present(OP_SH, 32'h0000_1001, 32'h0000_1234);
        #1;
        check("sh_mis_ades", ades, 1);
        check("sh_mis_badvaddr", badvaddr, 32'h0000_1001);
        check("sh_mis_stall", stall, 0);
        tick();
        check("sh_mis_req", mem.data_req, 0);
        present(OP_SW, 32'h0000_1002, 32'h0);
        #1;
        check("sw_mis_ades", ades, 1);
        check("sw_mis_stall", stall, 0);
        tick();
        check("sw_mis_req", mem.data_req, 0);

        // Non-store opcode at a misaligned address is ignored entirely
        present(6'h23, 32'h0000_1001, 32'h0);
        #1;
        check("nonstore_ades", ades, 0);
        check("nonstore_stall", stall, 0);
        tick();
        check("nonstore_req", mem.data_req, 0);
        idle_inputs();
        tick();

        // SW with addr_ok after 3 extra REQ cycles and data_ok two cycles later
        push_exp(32'h0000_2000, 2'd2, 32'hDEAD_BEEF, 4'b1111);
        sc = 0; rc = 0; dc = 0;
        for (int i = 0; i < 8; i++) begin
            st_valid = (i == 0);
            instr = {OP_SW, 26'h0};
            addr = 32'h0000_2000;
            rt_data = 32'hDEAD_BEEF;
            mem.data_addr_ok = (i == 4);
            mem.data_data_ok = (i == 6);
            #1;
            if (stall) sc++;
            if (mem.data_req) rc++;
            if (st_done) dc++;
            tick();
        end
        exp_done++;
        check("sw_slow_stall_cycles", sc, 6);
        check("sw_slow_req_cycles", rc, 4);
        check("sw_slow_done_pulses", dc, 1);
        idle_inputs();

        // Byte/half lane coverage
        quick_store("sb_0", OP_SB, 32'h0000_0100, 32'h1234_5677, 2'd0, 32'h7777_7777, 4'b0001);
        quick_store("sb_1", OP_SB, 32'h0000_0101, 32'h0000_003C, 2'd0, 32'h3C3C_3C3C, 4'b0010);
        quick_store("sb_2", OP_SB, 32'h0000_0102, 32'h0000_00C3, 2'd0, 32'hC3C3_C3C3, 4'b0100);
        quick_store("sh_0", OP_SH, 32'h0000_2000, 32'h1234_BEEF, 2'd1, 32'hBEEF_BEEF, 4'b0011);
        quick_store("sh_2", OP_SH, 32'h0000_3002, 32'h0000_5A5A, 2'd1, 32'h5A5A_5A5A, 4'b1100);
        quick_store("sw_0", OP_SW, 32'h0000_3000, 32'h89AB_CDEF, 2'd2, 32'h89AB_CDEF, 4'b1111);

        // Flush in the second REQ cycle drops the request
        push_exp(32'h0000_2002, 2'd1, 32'hBEEF_BEEF, 4'b1100);
        present(OP_SH, 32'h0000_2002, 32'h1234_BEEF);
        #1;
        check("fl_accept_stall", stall, 1);
        tick();
        st_valid = 1'b0;
        #1;
        check("fl_req1", mem.data_req, 1);
        tick();
        flush = 1'b1;
        #1;
        check("fl_req2_done", st_done, 0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_dropped_req", mem.data_req, 0);
        check("fl_dropped_stall", stall, 0);
        mem.data_data_ok = 1'b1;
        #1;
        check("idle_data_ok_done", st_done, 0);
        tick();
        mem.data_data_ok = 1'b0;

        // Both handshakes together, then a back-to-back SW
        push_exp(32'h0000_4000, 2'd2, 32'h1122_3344, 4'b1111);
        present(OP_SW, 32'h0000_4000, 32'h1122_3344);
        tick();
        st_valid = 1'b0;
        mem.data_addr_ok = 1'b1;
        mem.data_data_ok = 1'b1;
        exp_done++;
        #1;
        check("b2b_done", st_done, 1);
        tick();
        mem.data_addr_ok = 1'b0;
        mem.data_data_ok = 1'b0;
        push_exp(32'h0000_4004, 2'd2, 32'h5566_7788, 4'b1111);
        present(OP_SW, 32'h0000_4004, 32'h5566_7788);
        #1;
        check("b2b_second_accept", stall, 1);
        tick();
        st_valid = 1'b0;
        #1;
        check("b2b_second_req", mem.data_req, 1);
        mem.data_addr_ok = 1'b1;
        mem.data_data_ok = 1'b1;
        exp_done++;
        tick();
        idle_inputs();

        // Flush alongside addr_ok and flush in WAIT are both ignored
        push_exp(32'h0000_6000, 2'd2, 32'hCAFE_F00D, 4'b1111);
        present(OP_SW, 32'h0000_6000, 32'hCAFE_F00D);
        tick();
        st_valid = 1'b0;
        mem.data_addr_ok = 1'b1;
        flush = 1'b1;
        #1;
        check("cmt_flush_stall", stall, 1);
        tick();
        mem.data_addr_ok = 1'b0;
        #1;
        check("wait_flush_stall", stall, 1);
        check("wait_flush_req", mem.data_req, 0);
        tick();
        flush = 1'b0;
        mem.data_data_ok = 1'b1;
        exp_done++;
        #1;
        check("wait_done", st_done, 1);
        tick();
        idle_inputs();

        // Flush in the accept cycle blocks acceptance
        present(OP_SW, 32'h0000_7000, 32'h0);
        flush = 1'b1;
        #1;
        check("acc_flush_stall", stall, 0);
        tick();
        idle_inputs();
        #1;
        check("acc_flush_req", mem.data_req, 0);
        tick();

        // Reset during WAIT clears outputs at once and abandons the write
        push_exp(32'h0000_5000, 2'd2, 32'h0BAD_F00D, 4'b1111);
        present(OP_SW, 32'h0000_5000, 32'h0BAD_F00D);
        tick();
        st_valid = 1'b0;
        mem.data_addr_ok = 1'b1;
        tick();
        mem.data_addr_ok = 1'b0;
        #1;
        check("rw_wait_stall", stall, 1);
        #1;
        rst = 1'b1;
        #1;
        check("rw_req", mem.data_req, 0);
        check("rw_wr", mem.data_wr, 0);
        check("rw_size", mem.data_size, 0);
        check("rw_addr", mem.data_addr, 0);
        check("rw_wdata", mem.data_wdata, 0);
        check("rw_wstrb", mem.data_wstrb, 0);
        check("rw_stall", stall, 0);
        tick();
        tick();
        rst = 1'b0;
        mem.data_data_ok = 1'b1;
        #1;
        check("rw_late_done", st_done, 0);
        check("rw_late_stall", stall, 0);
        tick();
        idle_inputs();
        tick();

        check("scoreboard_empty", exp_q.size(), 0);
        check("done_pulse_count", done_cnt, exp_done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
